host_work_link: RTL and testbench
=================================

HOST_WORK_LINK -- requirements
Module: host_work_link

Interface
REQ-001 The block SHALL expose parameter KEY_BYTES, default 136, the number of key bytes per work unit.
REQ-002 The block SHALL expose parameter MSG_BYTES, default 128, the number of message bytes per work unit.
REQ-003 The block SHALL expose parameter NONCE_BYTES, default 8, the number of result bytes returned.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 rx_data  in  8  host byte stream into the block.
REQ-007 rx_valid  in  1  rx_data valid.
REQ-008 rx_ready  out  1  block accepts rx_data this cycle.
REQ-009 key  out  1088  assembled key for the connector.
REQ-010 message  out  1024  assembled message for the connector.
REQ-011 work_valid  out  1  key/message complete and stable; search may run.
REQ-012 nonce  in  64  nonce from the connector.
REQ-013 correct  in  1  connector reports a valid nonce.
REQ-014 tx_data  out  8  result byte to host.
REQ-015 tx_valid  out  1  tx_data valid.
REQ-016 tx_ready  in  1  host accepts tx_data this cycle.

Function
REQ-017 The FSM SHALL have states LOAD_KEY, LOAD_MSG, RUN and SEND; byte counter cnt SHALL be 8 bits.
REQ-018 rx_ready SHALL be 1 only in LOAD_KEY and LOAD_MSG; a byte transfers when rx_valid and rx_ready are both 1.
REQ-019 In LOAD_KEY, each transfer SHALL shift key left 8 bits, inserting rx_data at key[7:0] (first byte ends in key[1087:1080]).
REQ-020 In LOAD_KEY, the transfer with cnt == KEY_BYTES-1 SHALL clear cnt and go to LOAD_MSG; otherwise cnt SHALL increment.
REQ-021 LOAD_MSG SHALL shift message identically, going to RUN on the transfer with cnt == MSG_BYTES-1.
REQ-022 Cycles with rx_valid=0 SHALL leave key, message, cnt and state unchanged.
REQ-023 work_valid SHALL be 1 exactly while in RUN, starting the cycle after the final message byte transfers.
REQ-024 correct SHALL be sampled only in RUN; a 1 in RUN SHALL latch nonce into an internal register and go to SEND.
REQ-025 correct asserted in any other state SHALL be ignored.
REQ-026 In SEND, tx_valid SHALL be 1 and tx_data SHALL be latched-nonce byte cnt, MSB first (byte 0 = nonce[63:56]).
REQ-027 tx_data SHALL hold stable while tx_valid=1 and tx_ready=0.
REQ-028 Each SEND transfer SHALL advance cnt; the transfer with cnt == NONCE_BYTES-1 SHALL clear cnt and go to LOAD_KEY.
REQ-029 key and message SHALL hold their values in RUN and SEND; they SHALL change only by shifting during the next load.
REQ-030 Latency: work_valid SHALL be 1 the cycle after the last rx transfer; tx_valid SHALL be 1 the cycle after correct is sampled.

Reset
REQ-031 When rst=1 at a clock edge, state SHALL become LOAD_KEY and cnt, key, message and the latched nonce SHALL become 0, regardless of current state.
REQ-032 After reset, work_valid, tx_valid and tx_data SHALL be 0 and rx_ready SHALL be 1.
REQ-033 Reset mid-load or mid-send SHALL discard the partial work unit or result, and no further tx byte SHALL be emitted.

Structure
REQ-034 Package host_link_pkg SHALL hold the KEY_BYTES, MSG_BYTES and NONCE_BYTES defaults and the state encoding.
REQ-035 Byte serialization of the latched nonce SHALL be a sub-module named nonce_serializer.

Verification
REQ-036 Key bytes 0x00..0x87 then message bytes 0xFF repeated, rx_valid held 1 -> key[1087:1080]=0x00, key[7:0]=0x87, message all-ones, work_valid=1 the cycle after byte 264.
REQ-037 rx_valid toggled 1/0 every cycle during the load -> same final key and message; work_valid rises the cycle after the 264th transfer.
REQ-038 In RUN, nonce=64'h0123456789ABCDEF with correct=1, tx_ready=1 -> tx_data 01,23,45,67,89,AB,CD,EF on 8 consecutive cycles, then state LOAD_KEY with rx_ready=1.
REQ-039 tx_ready held 0 for 5 cycles at byte 3 -> tx_data stays 0x67 with tx_valid=1 for those cycles; nonce input changes during SEND have no effect on tx_data.
REQ-040 correct=1 during LOAD_MSG -> ignored, with no tx_valid; rst=1 at key byte 50 -> rx_ready=1, key=0, and a full reload completes normally.

Source files
------------

// File: rtl/host_link_pkg.sv
// Shared defaults and FSM encoding for the host work link and its serializer.
package host_link_pkg;

  localparam int unsigned KEY_BYTES_DEF   = 136;
  localparam int unsigned MSG_BYTES_DEF   = 128;
  localparam int unsigned NONCE_BYTES_DEF = 8;

  typedef enum logic [1:0] {
    LOAD_KEY = 2'd0,
    LOAD_MSG = 2'd1,
    RUN      = 2'd2,
    SEND     = 2'd3
  } link_state_e;

endpackage

// File: rtl/nonce_serializer.sv
// Holds the nonce captured on a successful search and presents one byte of it,
// MSB first, selected by the caller's byte index.
module nonce_serializer
  import host_link_pkg::*;
#(
  parameter int unsigned NONCE_BYTES = NONCE_BYTES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_i,
  input  logic [NONCE_BYTES*8-1:0] nonce_i,
  input  logic [7:0]               idx_i,
  output logic [7:0]               byte_o
);

  localparam int unsigned NW = NONCE_BYTES * 8;

  logic [NW-1:0] nonce_q;
  logic [NW-1:0] nonce_d;
  logic [NW-1:0] shifted;

  always_comb begin
    nonce_d = nonce_q;
    if (load_i) nonce_d = nonce_i;
  end

  always_ff @(posedge clk) begin
    if (rst) nonce_q <= '0;
    else     nonce_q <= nonce_d;
  end

  // Shifting left by whole bytes keeps byte idx at the top, so byte 0 is the MSB.
  assign shifted = nonce_q << {idx_i, 3'b000};
  assign byte_o  = shifted[NW-1 -: 8];

endmodule

// File: rtl/host_work_link.sv
// Loads a key and message from the host byte stream, holds them while the
// connector searches, then returns the winning nonce to the host byte by byte.
module host_work_link
  import host_link_pkg::*;
#(
  parameter int unsigned KEY_BYTES   = KEY_BYTES_DEF,
  parameter int unsigned MSG_BYTES   = MSG_BYTES_DEF,
  parameter int unsigned NONCE_BYTES = NONCE_BYTES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic [KEY_BYTES*8-1:0]   key,
  output logic [MSG_BYTES*8-1:0]   message,
  output logic                     work_valid,
  input  logic [NONCE_BYTES*8-1:0] nonce,
  input  logic                     correct,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [1:0]               state_o
);

  localparam int unsigned KW = KEY_BYTES * 8;
  localparam int unsigned MW = MSG_BYTES * 8;
  localparam logic [7:0] KEY_LAST   = 8'(KEY_BYTES - 1);
  localparam logic [7:0] MSG_LAST   = 8'(MSG_BYTES - 1);
  localparam logic [7:0] NONCE_LAST = 8'(NONCE_BYTES - 1);

  // Handshakes: a byte moves on rx when rx_valid && rx_ready at a rising edge,
  // and on tx when tx_valid && tx_ready; a stalled tx byte holds unchanged.
  link_state_e    state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [KW-1:0]  key_q, key_d;
  logic [MW-1:0]  msg_q, msg_d;
  logic           load_nonce;
  logic [7:0]     ser_byte;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    key_d      = key_q;
    msg_d      = msg_q;
    rx_ready   = 1'b0;
    tx_valid   = 1'b0;
    load_nonce = 1'b0;
    case (state_q)
      LOAD_KEY: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          key_d = {key_q[KW-9:0], rx_data};
          if (cnt_q == KEY_LAST) begin
            cnt_d   = 8'd0;
            state_d = LOAD_MSG;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      LOAD_MSG: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          msg_d = {msg_q[MW-9:0], rx_data};
          if (cnt_q == MSG_LAST) begin
            cnt_d   = 8'd0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      RUN: begin
        if (correct) begin
          load_nonce = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          if (cnt_q == NONCE_LAST) begin
            cnt_d   = 8'd0;
            state_d = LOAD_KEY;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = LOAD_KEY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_KEY;
      cnt_q   <= 8'd0;
      key_q   <= '0;
      msg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      msg_q   <= msg_d;
    end
  end

  nonce_serializer #(
    .NONCE_BYTES(NONCE_BYTES)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .load_i (load_nonce),
    .nonce_i(nonce),
    .idx_i  (cnt_q),
    .byte_o (ser_byte)
  );

  assign tx_data    = (state_q == SEND) ? ser_byte : 8'h00;
  assign work_valid = (state_q == RUN);
  assign key        = key_q;
  assign message    = msg_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_host_work_link.sv
// Directed bench for host_work_link: loads, nonce return with stalls, ignored
// correct outside RUN, and resets mid-load and mid-send.
module tb_host_work_link;
  import host_link_pkg::*;

  logic          clk;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [1087:0] key;
  logic [1023:0] message;
  logic          work_valid;
  logic [63:0]   nonce;
  logic          correct;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [1:0]    state_o;

  int checks = 0;
  int errors = 0;
  logic [7:0]    exp_q[$];
  logic [1087:0] exp_key;
  logic [1023:0] exp_msg;

  host_work_link dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .key       (key),
    .message   (message),
    .work_valid(work_valid),
    .nonce     (nonce),
    .correct   (correct),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .state_o   (state_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b0;
    correct = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Driver tasks: inputs change on the falling edge, outputs are read there too.
  function automatic logic [7:0] unit_byte(input int i);
    return (i < 136) ? 8'(i) : 8'hFF;
  endfunction

  task automatic drive_rx(input logic [7:0] b, input logic v);
    rx_data  = b;
    rx_valid = v;
    @(negedge clk);
  endtask

  task automatic load_range(input int first, input int last, input bit toggle);
    for (int i = first; i <= last; i++) begin
      drive_rx(unit_byte(i), 1'b1);
      if (toggle) drive_rx(8'h5A, 1'b0);
    end
    rx_valid = 1'b0;
  endtask

  task automatic check_work(input string tag);
    check({tag, "_key_first"}, 64'(key[1087:1080]), 64'h00);
    check({tag, "_key_last"}, 64'(key[7:0]), 64'h87);
    for (int c = 0; c < 17; c++)
      check($sformatf("%s_key_%0d", tag, c), key[c*64 +: 64], exp_key[c*64 +: 64]);
    for (int c = 0; c < 16; c++)
      check($sformatf("%s_msg_%0d", tag, c), message[c*64 +: 64], exp_msg[c*64 +: 64]);
  endtask

  task automatic load_unit(input string tag, input int first, input bit toggle);
    load_range(first, 262, toggle);
    check({tag, "_wv_before_last"}, 64'(work_valid), 64'd0);
    drive_rx(unit_byte(263), 1'b1);
    rx_valid = 1'b0;
    check({tag, "_wv_after_last"}, 64'(work_valid), 64'd1);
    check({tag, "_state_run"}, 64'(state_o), 64'(RUN));
    check({tag, "_rx_ready_run"}, 64'(rx_ready), 64'd0);
    check_work(tag);
  endtask

  task automatic fire_nonce(input logic [63:0] n);
    nonce   = n;
    correct = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(n[63-8*i -: 8]);
    @(negedge clk);
    correct = 1'b0;
    check("send_tx_valid_latency", 64'(tx_valid), 64'd1);
    check("send_wv_low", 64'(work_valid), 64'd0);
    check("send_state", 64'(state_o), 64'(SEND));
  endtask

  // Scoreboard: pops expected nonce bytes as the DUT hands them over.
  task automatic collect(input int stall_at, input int stall_len, input int max_pop,
                         input bit rnd_ready, output int cycles);
    int popped;
    int stalled;
    int target;
    popped  = 0;
    stalled = 0;
    cycles  = 0;
    target  = (exp_q.size() < max_pop) ? exp_q.size() : max_pop;
    while (popped < target && cycles < 200) begin
      nonce = {$urandom, $urandom};
      if (popped == stall_at && stalled < stall_len) begin
        tx_ready = 1'b0;
        stalled++;
        check("tx_stall_valid", 64'(tx_valid), 64'd1);
        check("tx_stall_data", 64'(tx_data), 64'(exp_q[0]));
      end else begin
        tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (tx_ready && tx_valid) begin
          check($sformatf("tx_byte_%0d", popped), 64'(tx_data), 64'(exp_q.pop_front()));
          popped++;
        end
      end
      cycles++;
      @(negedge clk);
    end
    check("tx_drained", 64'(popped), 64'(target));
  endtask

  task automatic idle_run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("run_hold_wv", 64'(work_valid), 64'd1);
      check("run_no_tx", 64'(tx_valid), 64'd0);
      check("run_key_hold", key[1087:1024], exp_key[1087:1024]);
    end
  endtask

  initial begin
    int cycles;
    rst = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; nonce = 64'd0;
    correct = 1'b0; tx_ready = 1'b1;
    exp_key = '0;
    for (int i = 0; i < 136; i++) exp_key[1087-8*i -: 8] = 8'(i);
    exp_msg = '1;

    apply_reset();
    check("rst_rx_ready", 64'(rx_ready), 64'd1);
    check("rst_work_valid", 64'(work_valid), 64'd0);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_state", 64'(state_o), 64'(LOAD_KEY));
    check("rst_key_top", key[1087:1024], 64'd0);
    check("rst_msg_top", message[1023:960], 64'd0);

    // Back-to-back load, then nonce return with no backpressure.
    load_unit("load_full", 0, 1'b0);
    idle_run(3);
    fire_nonce(64'h0123456789ABCDEF);
    collect(-1, 0, 8, 1'b0, cycles);
    check("send_consecutive", 64'(cycles), 64'd8);
    check("after_send_state", 64'(state_o), 64'(LOAD_KEY));
    check("after_send_rx_ready", 64'(rx_ready), 64'd1);
    check("after_send_tx_valid", 64'(tx_valid), 64'd0);
    check("after_send_key_hold", key[1087:1024], exp_key[1087:1024]);

    // Gapped load, then a 5-cycle stall on byte 3 with nonce input wandering.
    load_unit("load_toggle", 0, 1'b1);
    fire_nonce(64'h0123456789ABCDEF);
    collect(3, 5, 8, 1'b0, cycles);
    check("stall_cycles", 64'(cycles), 64'd13);
    check("stall_end_state", 64'(state_o), 64'(LOAD_KEY));

    // correct raised during LOAD_MSG is ignored.
    load_range(0, 145, 1'b0);
    for (int i = 0; i < 3; i++) begin
      correct = 1'b1;
      nonce = {$urandom, $urandom};
      @(negedge clk);
      check("msg_correct_no_tx", 64'(tx_valid), 64'd0);
      check("msg_correct_state", 64'(state_o), 64'(LOAD_MSG));
    end
    correct = 1'b0;
    load_unit("load_after_ignore", 146, 1'b0);

    // Reset in RUN, then reset partway through the key.
    apply_reset();
    load_range(0, 49, 1'b0);
    rx_data = 8'd50;
    rx_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx_valid = 1'b0;
    check("midload_rx_ready", 64'(rx_ready), 64'd1);
    check("midload_state", 64'(state_o), 64'(LOAD_KEY));
    for (int c = 0; c < 17; c++)
      check($sformatf("midload_key_%0d", c), key[c*64 +: 64], 64'd0);
    load_unit("load_after_rst", 0, 1'b0);

    // Random backpressure on a random nonce.
    fire_nonce({$urandom, $urandom});
    collect(-1, 0, 8, 1'b1, cycles);
    check("rnd_end_state", 64'(state_o), 64'(LOAD_KEY));

    // Reset after three bytes of a send: nothing more may leave.
    load_unit("load_pre_sendrst", 0, 1'b0);
    fire_nonce(64'hFEDCBA9876543210);
    collect(-1, 0, 3, 1'b0, cycles);
    rst = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("sendrst_state", 64'(state_o), 64'(LOAD_KEY));
    for (int i = 0; i < 10; i++) begin
      check("sendrst_no_tx", 64'(tx_valid), 64'd0);
      check("sendrst_tx_data", 64'(tx_data), 64'd0);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
